// File: rtl/apb_master_arbiter.sv
// Two-master to one-slave APB arbiter: round-robin grant, atomic registered SETUP/ACCESS
// sequence toward the slave, and a wait-state watchdog that aborts hung transfers.
module apb_master_arbiter #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    // Master handshake: psel is the request and stays high until a one-cycle
    // pready pulse returns; prdata/pslverr are valid only while pready is high.
    input  logic                m0_psel_i,
    input  logic [ADDR_W-1:0]   m0_paddr_i,
    input  logic                m0_pwrite_i,
    input  logic [DATA_W-1:0]   m0_pwdata_i,
    input  logic [DATA_W/8-1:0] m0_pstrb_i,
    output logic [DATA_W-1:0]   m0_prdata_o,
    output logic                m0_pready_o,
    output logic                m0_pslverr_o,
    input  logic                m1_psel_i,
    input  logic [ADDR_W-1:0]   m1_paddr_i,
    input  logic                m1_pwrite_i,
    input  logic [DATA_W-1:0]   m1_pwdata_i,
    input  logic [DATA_W/8-1:0] m1_pstrb_i,
    output logic [DATA_W-1:0]   m1_prdata_o,
    output logic                m1_pready_o,
    output logic                m1_pslverr_o,
    output logic                s_psel_o,
    output logic                s_penable_o,
    output logic [ADDR_W-1:0]   s_paddr_o,
    output logic                s_pwrite_o,
    output logic [DATA_W-1:0]   s_pwdata_o,
    output logic [DATA_W/8-1:0] s_pstrb_o,
    input  logic [DATA_W-1:0]   s_prdata_i,
    input  logic                s_pready_i,
    input  logic                s_pslverr_i,
    output logic [1:0]          grant_o,
    output logic                timeout_o,
    output logic [1:0]          state_o
);

    localparam int STRB_W = DATA_W / 8;
    localparam bit WDT_EN = (TIMEOUT > 0);
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_I);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETUP    = 2'd1,
        ACCESS   = 2'd2,
        COMPLETE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                last_q, last_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          grant_q, grant_d;
    logic                timeout_q, timeout_d;
    logic                s_psel_q, s_psel_d;
    logic                s_penable_q, s_penable_d;
    logic [ADDR_W-1:0]   s_paddr_q, s_paddr_d;
    logic                s_pwrite_q, s_pwrite_d;
    logic [DATA_W-1:0]   s_pwdata_q, s_pwdata_d;
    logic [STRB_W-1:0]   s_pstrb_q, s_pstrb_d;
    logic [DATA_W-1:0]   m0_prdata_q, m0_prdata_d;
    logic                m0_pready_q, m0_pready_d;
    logic                m0_pslverr_q, m0_pslverr_d;
    logic [DATA_W-1:0]   m1_prdata_q, m1_prdata_d;
    logic                m1_pready_q, m1_pready_d;
    logic                m1_pslverr_q, m1_pslverr_d;

    logic                pick1;
    logic                rsp_valid;
    logic [DATA_W-1:0]   rsp_data;
    logic                rsp_err;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            last_q       <= 1'b1;
            cnt_q        <= '0;
            grant_q      <= 2'b00;
            timeout_q    <= 1'b0;
            s_psel_q     <= 1'b0;
            s_penable_q  <= 1'b0;
            s_paddr_q    <= '0;
            s_pwrite_q   <= 1'b0;
            s_pwdata_q   <= '0;
            s_pstrb_q    <= '0;
            m0_prdata_q  <= '0;
            m0_pready_q  <= 1'b0;
            m0_pslverr_q <= 1'b0;
            m1_prdata_q  <= '0;
            m1_pready_q  <= 1'b0;
            m1_pslverr_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            timeout_q    <= timeout_d;
            s_psel_q     <= s_psel_d;
            s_penable_q  <= s_penable_d;
            s_paddr_q    <= s_paddr_d;
            s_pwrite_q   <= s_pwrite_d;
            s_pwdata_q   <= s_pwdata_d;
            s_pstrb_q    <= s_pstrb_d;
            m0_prdata_q  <= m0_prdata_d;
            m0_pready_q  <= m0_pready_d;
            m0_pslverr_q <= m0_pslverr_d;
            m1_prdata_q  <= m1_prdata_d;
            m1_pready_q  <= m1_pready_d;
            m1_pslverr_q <= m1_pslverr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        timeout_d    = timeout_q;
        s_psel_d     = s_psel_q;
        s_penable_d  = s_penable_q;
        s_paddr_d    = s_paddr_q;
        s_pwrite_d   = s_pwrite_q;
        s_pwdata_d   = s_pwdata_q;
        s_pstrb_d    = s_pstrb_q;
        m0_prdata_d  = m0_prdata_q;
        m0_pready_d  = m0_pready_q;
        m0_pslverr_d = m0_pslverr_q;
        m1_prdata_d  = m1_prdata_q;
        m1_pready_d  = m1_pready_q;
        m1_pslverr_d = m1_pslverr_q;
        pick1        = 1'b0;
        rsp_valid    = 1'b0;
        rsp_data     = '0;
        rsp_err      = 1'b0;

        case (state_q)
            IDLE: begin
                if (m0_psel_i || m1_psel_i) begin
                    // last_q == 1 means m1 went last, so m0 wins a tie
                    pick1       = m1_psel_i && (!m0_psel_i || !last_q);
                    grant_d     = pick1 ? 2'b10 : 2'b01;
                    last_d      = pick1;
                    s_paddr_d   = pick1 ? m1_paddr_i  : m0_paddr_i;
                    s_pwrite_d  = pick1 ? m1_pwrite_i : m0_pwrite_i;
                    s_pwdata_d  = pick1 ? m1_pwdata_i : m0_pwdata_i;
                    s_pstrb_d   = pick1 ? m1_pstrb_i  : m0_pstrb_i;
                    s_psel_d    = 1'b1;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                s_penable_d = 1'b1;
                cnt_d       = '0;
                state_d     = ACCESS;
            end
            ACCESS: begin
                if (s_pready_i) begin
                    rsp_valid = 1'b1;
                    rsp_data  = s_pwrite_q ? '0 : s_prdata_i;
                    rsp_err   = s_pslverr_i;
                end else if (WDT_EN && cnt_q == CNT_LAST) begin
                    rsp_valid = 1'b1;
                    rsp_err   = 1'b1;
                    timeout_d = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end

                if (rsp_valid) begin
                    s_psel_d    = 1'b0;
                    s_penable_d = 1'b0;
                    state_d     = COMPLETE;
                    if (grant_q[0]) begin
                        m0_prdata_d  = rsp_data;
                        m0_pslverr_d = rsp_err;
                        m0_pready_d  = 1'b1;
                    end
                    if (grant_q[1]) begin
                        m1_prdata_d  = rsp_data;
                        m1_pslverr_d = rsp_err;
                        m1_pready_d  = 1'b1;
                    end
                end
            end
            COMPLETE: begin
                m0_prdata_d  = '0;
                m0_pready_d  = 1'b0;
                m0_pslverr_d = 1'b0;
                m1_prdata_d  = '0;
                m1_pready_d  = 1'b0;
                m1_pslverr_d = 1'b0;
                grant_d      = 2'b00;
                timeout_d    = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign m0_prdata_o  = m0_prdata_q;
    assign m0_pready_o  = m0_pready_q;
    assign m0_pslverr_o = m0_pslverr_q;
    assign m1_prdata_o  = m1_prdata_q;
    assign m1_pready_o  = m1_pready_q;
    assign m1_pslverr_o = m1_pslverr_q;
    assign s_psel_o     = s_psel_q;
    assign s_penable_o  = s_penable_q;
    assign s_paddr_o    = s_paddr_q;
    assign s_pwrite_o   = s_pwrite_q;
    assign s_pwdata_o   = s_pwdata_q;
    assign s_pstrb_o    = s_pstrb_q;
    assign grant_o      = grant_q;
    assign timeout_o    = timeout_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: directed and random transfers against a simple
// configurable slave, with per-master response queues and a grant-order queue.
module tb_apb_master_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst_n_i;
    logic          m0_psel_i, m1_psel_i;
    logic [AW-1:0] m0_paddr_i, m1_paddr_i;
    logic          m0_pwrite_i, m1_pwrite_i;
    logic [DW-1:0] m0_pwdata_i, m1_pwdata_i;
    logic [SW-1:0] m0_pstrb_i, m1_pstrb_i;
    logic [DW-1:0] m0_prdata_o, m1_prdata_o;
    logic          m0_pready_o, m1_pready_o;
    logic          m0_pslverr_o, m1_pslverr_o;
    logic          s_psel_o, s_penable_o;
    logic [AW-1:0] s_paddr_o;
    logic          s_pwrite_o;
    logic [DW-1:0] s_pwdata_o;
    logic [SW-1:0] s_pstrb_o;
    logic [DW-1:0] s_prdata_i;
    logic          s_pready_i, s_pslverr_i;
    logic [1:0]    grant_o;
    logic          timeout_o;
    logic [1:0]    state_o;

    int checks = 0;
    int errors = 0;

    // slave model configuration
    int            slv_waits = 0;
    bit            slv_hang  = 1'b0;
    bit            slv_err   = 1'b0;
    logic [DW-1:0] slv_rdata = '0;
    int            acc_cnt   = 0;

    logic [DW:0]   exp_q0[$];
    logic [DW:0]   exp_q1[$];
    logic [1:0]    exp_grant_q[$];
    logic [1:0]    prev_grant = 2'b00;

    apb_master_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(15)) dut (
        .clk_i(clk), .rst_n_i(rst_n_i),
        .m0_psel_i(m0_psel_i), .m0_paddr_i(m0_paddr_i), .m0_pwrite_i(m0_pwrite_i),
        .m0_pwdata_i(m0_pwdata_i), .m0_pstrb_i(m0_pstrb_i), .m0_prdata_o(m0_prdata_o),
        .m0_pready_o(m0_pready_o), .m0_pslverr_o(m0_pslverr_o),
        .m1_psel_i(m1_psel_i), .m1_paddr_i(m1_paddr_i), .m1_pwrite_i(m1_pwrite_i),
        .m1_pwdata_i(m1_pwdata_i), .m1_pstrb_i(m1_pstrb_i), .m1_prdata_o(m1_prdata_o),
        .m1_pready_o(m1_pready_o), .m1_pslverr_o(m1_pslverr_o),
        .s_psel_o(s_psel_o), .s_penable_o(s_penable_o), .s_paddr_o(s_paddr_o),
        .s_pwrite_o(s_pwrite_o), .s_pwdata_o(s_pwdata_o), .s_pstrb_o(s_pstrb_o),
        .s_prdata_i(s_prdata_i), .s_pready_i(s_pready_i), .s_pslverr_i(s_pslverr_i),
        .grant_o(grant_o), .timeout_o(timeout_o), .state_o(state_o)
    );

    // clock / global time limit
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_time_limit reached got=stuck exp=finish");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // slave: ready after slv_waits ACCESS cycles unless hung; always offers read data
    always @(negedge clk) begin
        if (s_psel_o && s_penable_o) begin
            if (!slv_hang && acc_cnt == slv_waits) begin
                s_pready_i  = 1'b1;
                s_prdata_i  = slv_rdata;
                s_pslverr_i = slv_err;
            end else begin
                s_pready_i  = 1'b0;
                s_prdata_i  = $urandom;
                s_pslverr_i = 1'b0;
            end
            acc_cnt++;
        end else begin
            s_pready_i  = 1'b0;
            s_prdata_i  = '0;
            s_pslverr_i = 1'b0;
            acc_cnt     = 0;
        end
    end

    // scoreboard monitor
    always @(negedge clk) begin
        logic [DW:0] e;
        if (rst_n_i) begin
            if (m0_pready_o) begin
                check("m0_grant", grant_o, 2'b01);
                check("m1_quiet", {m1_pready_o, m1_pslverr_o, m1_prdata_o}, '0);
                if (exp_q0.size() == 0) check("m0_unexpected", m0_pready_o, 1'b0);
                else begin
                    e = exp_q0.pop_front();
                    check("m0_rsp", {m0_pslverr_o, m0_prdata_o}, e);
                end
            end
            if (m1_pready_o) begin
                check("m1_grant", grant_o, 2'b10);
                check("m0_quiet", {m0_pready_o, m0_pslverr_o, m0_prdata_o}, '0);
                if (exp_q1.size() == 0) check("m1_unexpected", m1_pready_o, 1'b0);
                else begin
                    e = exp_q1.pop_front();
                    check("m1_rsp", {m1_pslverr_o, m1_prdata_o}, e);
                end
            end
            if (grant_o != 2'b00 && prev_grant == 2'b00 && exp_grant_q.size() > 0)
                check("grant_order", grant_o, exp_grant_q.pop_front());
        end
        prev_grant = grant_o;
    end

    task automatic set_master(input int m, input logic sel, input logic [AW-1:0] a,
                              input logic w, input logic [DW-1:0] d, input logic [SW-1:0] s);
        if (m == 0) begin
            m0_psel_i = sel; m0_paddr_i = a; m0_pwrite_i = w; m0_pwdata_i = d; m0_pstrb_i = s;
        end else begin
            m1_psel_i = sel; m1_paddr_i = a; m1_pwrite_i = w; m1_pwdata_i = d; m1_pstrb_i = s;
        end
    endtask

    // exp_lat < 0: shared-bus transfer, timing not checked; drop_early releases psel after one cycle
    task automatic xfer(input int m, input logic [AW-1:0] addr, input logic wr,
                        input logic [DW-1:0] wdata, input logic [SW-1:0] strb,
                        input int exp_lat, input bit drop_early);
        int          cyc = 0;
        int          psel_cyc = 0;
        int          pen_cyc = 0;
        bit          seen = 1'b0;
        logic [DW:0] e;
        logic [1:0]  own;
        own = (m == 0) ? 2'b01 : 2'b10;
        if (exp_lat >= 0) @(negedge clk);
        if (slv_hang) e = {1'b1, {DW{1'b0}}};
        else          e = {slv_err, wr ? {DW{1'b0}} : slv_rdata};
        if (m == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
        set_master(m, 1'b1, addr, wr, wdata, strb);
        while (!seen && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (grant_o == own && s_psel_o) begin
                check("slave_fields", {s_paddr_o, s_pwrite_o, s_pwdata_o, s_pstrb_o},
                      {addr, wr, wdata, strb});
                if (psel_cyc == 0) psel_cyc = cyc;
                if (pen_cyc == 0 && s_penable_o) pen_cyc = cyc;
            end
            if (cyc == 1 && exp_lat >= 0) begin
                check("state_setup", state_o, 2'd1);
                set_master(m, !drop_early, ~addr, ~wr, ~wdata, ~strb);
            end
            if ((m == 0) ? m0_pready_o : m1_pready_o) seen = 1'b1;
        end
        check("xfer_done", seen, 1'b1);
        if (seen) begin
            check("timeout_o", timeout_o, slv_hang);
            if (exp_lat >= 0) begin
                check("latency", cyc, exp_lat);
                check("psel_cycle", psel_cyc, 1);
                check("penable_cycle", pen_cyc, 2);
            end
        end
        set_master(m, 1'b0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        int w;
        rst_n_i = 1'b0;
        set_master(0, 1'b0, '0, 1'b0, '0, '0);
        set_master(1, 1'b0, '0, 1'b0, '0, '0);
        s_prdata_i = '0; s_pready_i = 1'b0; s_pslverr_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_outputs", |{m0_prdata_o, m0_pready_o, m0_pslverr_o, m1_prdata_o, m1_pready_o,
              m1_pslverr_o, s_psel_o, s_penable_o, s_paddr_o, s_pwrite_o, s_pwdata_o,
              s_pstrb_o, grant_o, timeout_o}, 1'b0);
        check("rst_state", state_o, 2'd0);
        rst_n_i = 1'b1;
        @(negedge clk);

        // simultaneous held requests after reset alternate m0, m1, m0, m1
        exp_grant_q.push_back(2'b01); exp_grant_q.push_back(2'b10);
        exp_grant_q.push_back(2'b01); exp_grant_q.push_back(2'b10);
        fork
            begin
                xfer(0, 10'h010, 1'b1, 32'h1111_0000, 4'hF, -1, 1'b0);
                xfer(0, 10'h014, 1'b1, 32'h1111_0001, 4'h3, -1, 1'b0);
            end
            begin
                xfer(1, 10'h020, 1'b1, 32'h2222_0000, 4'hC, -1, 1'b0);
                xfer(1, 10'h024, 1'b1, 32'h2222_0001, 4'h1, -1, 1'b0);
            end
        join

        // zero-wait write, then a read with three wait states
        slv_waits = 0;
        xfer(0, 10'h004, 1'b1, 32'hA5A5_0001, 4'hF, 3, 1'b0);
        slv_waits = 3; slv_rdata = 32'h0101_0164;
        xfer(1, 10'h008, 1'b0, 32'h0, 4'h0, 6, 1'b0);

        for (int i = 0; i < 8; i++) begin
            w = $urandom_range(0, 4);
            slv_waits = w;
            slv_rdata = $urandom;
            xfer($urandom_range(0, 1), AW'($urandom), 1'($urandom), $urandom,
                 SW'($urandom), 3 + w, 1'b0);
        end

        // hung slave: watchdog abort after 15 ACCESS cycles, then normal service resumes
        slv_hang = 1'b1;
        xfer(0, 10'h0F0, 1'b0, 32'h0, 4'h0, 17, 1'b0);
        slv_hang = 1'b0; slv_waits = 0; slv_rdata = 32'hCAFE_0042;
        xfer(1, 10'h0F4, 1'b0, 32'h0, 4'h0, 3, 1'b0);

        // slave error forwarded only to the owner
        slv_err = 1'b1; slv_rdata = 32'h0BAD_0BAD;
        xfer(1, 10'h100, 1'b1, 32'h5555_AAAA, 4'hF, 3, 1'b0);
        xfer(0, 10'h104, 1'b0, 32'h0, 4'h0, 3, 1'b0);
        slv_err = 1'b0;

        // master abandons the request: the response pulse still appears
        slv_rdata = 32'h0000_7777;
        xfer(0, 10'h108, 1'b0, 32'h0, 4'h0, 3, 1'b1);
        repeat (3) @(negedge clk);
        check("idle_after_drop", grant_o, 2'b00);

        // reset during ACCESS after an m0 grant; the next tie must still go to m0
        slv_hang = 1'b1;
        set_master(0, 1'b1, 10'h03C, 1'b0, '0, '0);
        repeat (5) @(negedge clk);
        check("pre_rst_access", {s_psel_o, s_penable_o}, 2'b11);
        #2 rst_n_i = 1'b0;
        #1;
        check("rst_async_slave", {s_psel_o, s_penable_o}, 2'b00);
        check("rst_async_outs", |{m0_prdata_o, m0_pready_o, m0_pslverr_o, m1_prdata_o,
              m1_pready_o, m1_pslverr_o, s_paddr_o, s_pwrite_o, s_pwdata_o, s_pstrb_o,
              grant_o, timeout_o}, 1'b0);
        check("rst_async_state", state_o, 2'd0);
        set_master(0, 1'b0, '0, 1'b0, '0, '0);
        slv_hang = 1'b0; slv_waits = 0; slv_rdata = 32'h0000_5A5A;
        @(negedge clk);
        rst_n_i = 1'b1;
        exp_grant_q.push_back(2'b01); exp_grant_q.push_back(2'b10);
        fork
            xfer(0, 10'h040, 1'b0, 32'h0, 4'h0, -1, 1'b0);
            xfer(1, 10'h044, 1'b0, 32'h0, 4'h0, -1, 1'b0);
        join

        repeat (3) @(negedge clk);
        check("queues_empty", exp_q0.size() + exp_q1.size() + exp_grant_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
